// File: rtl/regfile_mp_bypass.sv
// Multi-port register file: two read ports and two write ports (ALU and long-latency writeback),
// with optional write-to-read bypass, hardwired-zero register r0 and a per-register pending scoreboard.
module regfile_mp_bypass #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned OUT_REG  = 6,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  output logic            rd_busy1,
  output logic            rd_busy2,
  input  logic            wr_en0,
  input  logic [AW-1:0]   wr_addr0,
  input  logic [XLEN-1:0] wr_data0,
  input  logic            wr_en1,
  input  logic [AW-1:0]   wr_addr1,
  input  logic [XLEN-1:0] wr_data1,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic [XLEN-1:0] out_reg
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic             we0;
  logic             we1;
  logic             sb_we;

  // Accesses aimed at a hardwired-zero r0 are dropped before they reach storage or the bypass.
  assign we0   = wr_en0 && !((ZERO_REG != 0) && (wr_addr0 == '0));
  assign we1   = wr_en1 && !((ZERO_REG != 0) && (wr_addr1 == '0));
  assign sb_we = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

  // A new issue supersedes a returning result on the same register, so set is applied last.
  always_comb begin
    pending_nxt = pending;
    if (we1) pending_nxt[wr_addr1] = 1'b0;
    if (sb_we) pending_nxt[sb_addr] = 1'b1;
  end

  // Port 1 is written last so it wins an address conflict with port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[AW'(i)] <= '0;
      pending <= '0;
    end else begin
      if (we0) regs[wr_addr0] <= wr_data0;
      if (we1) regs[wr_addr1] <= wr_data1;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_busy1 = pending[rd_addr1];
    if (BYPASS != 0) begin
      if (we0 && (wr_addr0 == rd_addr1)) rd_data1 = wr_data0;
      if (we1 && (wr_addr1 == rd_addr1)) begin
        rd_data1 = wr_data1;
        rd_busy1 = 1'b0;
      end
    end
    if (rst || ((ZERO_REG != 0) && (rd_addr1 == '0))) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    rd_busy2 = pending[rd_addr2];
    if (BYPASS != 0) begin
      if (we0 && (wr_addr0 == rd_addr2)) rd_data2 = wr_data0;
      if (we1 && (wr_addr1 == rd_addr2)) begin
        rd_data2 = wr_data1;
        rd_busy2 = 1'b0;
      end
    end
    if (rst || ((ZERO_REG != 0) && (rd_addr2 == '0))) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end
  end

  // Debug tap shows only committed state, never bypassed data.
  assign out_reg = rst ? '0 : regs[AW'(OUT_REG)];

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Scoreboard bench for regfile_mp_bypass: a bypassing and a non-bypassing instance share stimulus
// and are checked against an array-based reference model of the architectural state.
module tb_regfile_mp_bypass;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned OUTR  = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   rd_addr1 = '0, rd_addr2 = '0;
  logic            wr_en0 = 1'b0, wr_en1 = 1'b0, sb_set = 1'b0;
  logic [AW-1:0]   wr_addr0 = '0, wr_addr1 = '0, sb_addr = '0;
  logic [XLEN-1:0] wr_data0 = '0, wr_data1 = '0;
  logic [XLEN-1:0] rd_data1, rd_data2, out_reg;
  logic            rd_busy1, rd_busy2;
  logic [XLEN-1:0] nb_rd_data1, nb_rd_data2, nb_out_reg;
  logic            nb_rd_busy1, nb_rd_busy2;

  always #5 clk = ~clk;

  regfile_mp_bypass #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(1), .OUT_REG(OUTR)) dut (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .sb_set(sb_set), .sb_addr(sb_addr), .out_reg(out_reg));

  regfile_mp_bypass #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(0), .OUT_REG(OUTR)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2), .rd_busy1(nb_rd_busy1), .rd_busy2(nb_rd_busy2),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .sb_set(sb_set), .sb_addr(sb_addr), .out_reg(nb_out_reg));

  typedef struct {
    int              cyc;
    logic [XLEN-1:0] d1, d2, nd1, nd2, outv;
    logic            b1, b2, nb1, nb2;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              errors = 0;
  int              cycle  = 0;
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_pend [NREGS];

  // Reference: architectural value, optionally overridden by this cycle's writes (port 1 first).
  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (rst || a == '0) return '0;
    if (byp && wr_en1 && wr_addr1 == a) return wr_data1;
    if (byp && wr_en0 && wr_addr0 == a) return wr_data0;
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    if (rst || a == '0) return 1'b0;
    if (byp && wr_en1 && wr_addr1 == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, queue the expectation, then advance the model.
  task automatic step(input bit r, input bit w0, input int a0, input logic [XLEN-1:0] d0,
                      input bit w1, input int a1, input logic [XLEN-1:0] d1,
                      input bit s, input int sa, input int ra1, input int ra2);
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    rst = r;
    wr_en0 = w0; wr_addr0 = AW'(a0); wr_data0 = d0;
    wr_en1 = w1; wr_addr1 = AW'(a1); wr_data1 = d1;
    sb_set = s;  sb_addr = AW'(sa);
    rd_addr1 = AW'(ra1); rd_addr2 = AW'(ra2);
    e.cyc  = cycle;
    e.d1   = exp_data(rd_addr1, 1'b1); e.d2  = exp_data(rd_addr2, 1'b1);
    e.nd1  = exp_data(rd_addr1, 1'b0); e.nd2 = exp_data(rd_addr2, 1'b0);
    e.b1   = exp_busy(rd_addr1, 1'b1); e.b2  = exp_busy(rd_addr2, 1'b1);
    e.nb1  = exp_busy(rd_addr1, 1'b0); e.nb2 = exp_busy(rd_addr2, 1'b0);
    e.outv = r ? '0 : m_reg[OUTR];
    q.push_back(e);
    if (r) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (w0 && a0 != 0) m_reg[a0] = d0;
      if (w1 && a1 != 0) m_reg[a1] = d1;
      if (w1) m_pend[a1] = 1'b0;
      if (s && sa != 0) m_pend[sa] = 1'b1;
    end
  endtask

  task automatic idle(input int ra1, input int ra2);
    step(0, 0, 0, '0, 0, 0, '0, 0, 0, ra1, ra2);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rd_data1", e.cyc, rd_data1, e.d1);
      chk("rd_data2", e.cyc, rd_data2, e.d2);
      chk("rd_busy1", e.cyc, XLEN'(rd_busy1), XLEN'(e.b1));
      chk("rd_busy2", e.cyc, XLEN'(rd_busy2), XLEN'(e.b2));
      chk("out_reg", e.cyc, out_reg, e.outv);
      chk("nb_rd_data1", e.cyc, nb_rd_data1, e.nd1);
      chk("nb_rd_data2", e.cyc, nb_rd_data2, e.nd2);
      chk("nb_rd_busy1", e.cyc, XLEN'(nb_rd_busy1), XLEN'(e.nb1));
      chk("nb_rd_busy2", e.cyc, XLEN'(nb_rd_busy2), XLEN'(e.nb2));
      chk("nb_out_reg", e.cyc, nb_out_reg, e.outv);
    end
  end

  initial begin
    for (int i = 0; i < int'(NREGS); i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    step(1, 0, 0, '0, 0, 0, '0, 0, 0, 3, 7);
    step(1, 0, 0, '0, 0, 0, '0, 0, 0, 6, 1);
    // dual write, then same-address conflict
    step(0, 1, 3, 32'hAAAA0000, 1, 7, 32'h12345678, 0, 0, 3, 7);
    idle(3, 7);
    step(0, 1, 4, 32'h11, 1, 4, 32'h22, 0, 0, 4, 3);
    idle(4, 7);
    // bypass from each port
    step(0, 1, 9, 32'hDEADBEEF, 0, 0, '0, 0, 0, 9, 4);
    step(0, 1, 9, 32'h00000001, 1, 9, 32'hCAFEF00D, 0, 0, 9, 9);
    idle(9, 9);
    // hardwired zero register
    step(0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    idle(0, 0);
    // scoreboard lifecycle on r10
    step(0, 0, 0, '0, 0, 0, '0, 1, 10, 10, 10);
    idle(10, 9);
    idle(10, 10);
    step(0, 1, 10, 32'h99, 0, 0, '0, 0, 0, 10, 10);
    step(0, 0, 0, '0, 1, 10, 32'h55, 0, 0, 10, 10);
    idle(10, 10);
    // set/clear collision on r12
    step(0, 0, 0, '0, 0, 0, '0, 1, 12, 12, 10);
    step(0, 0, 0, '0, 1, 12, 32'h77, 1, 12, 12, 12);
    idle(12, 12);
    // debug tap follows r6
    step(0, 1, 6, 32'h600D, 0, 0, '0, 0, 0, 6, 6);
    step(0, 0, 0, '0, 1, 6, 32'h6666, 0, 0, 6, 3);
    idle(6, 7);
    // async reset mid-cycle with writes and sb_set presented
    step(0, 0, 0, '0, 0, 0, '0, 1, 13, 13, 3);
    step(1, 1, 3, 32'hBAD0, 1, 7, 32'hBAD1, 1, 5, 3, 7);
    step(1, 1, 6, 32'hBAD2, 0, 0, '0, 1, 5, 5, 6);
    idle(5, 13);
    idle(3, 6);
    // randomized traffic over a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 60) == 0),
           1'($urandom), int'($urandom_range(0, 15)), $urandom,
           1'($urandom), int'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    idle(0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
- Parametrised successor to the core's 2-read/1-write register file.
- Two write ports: port 0 for the ALU result, port 1 for long-latency writeback (load/div).
- Optional same-cycle write-to-read bypass, optional hardwired-zero register, and a per-register pending scoreboard so decode can stall on outstanding long-latency results.
- Keeps the debug output tap, now at a parametrised register index.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2. Localparam AW = clog2(NREGS).
- ZERO_REG, 1, if 1, register 0 always reads 0, ignores writes and is never pending.
- BYPASS, 1, if 1, read ports return same-cycle write data and see same-cycle scoreboard clears.
- OUT_REG, 6, index of the register driven on out_reg; must be below NREGS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- rd_addr1  in  AW  read port 1 address.
- rd_addr2  in  AW  read port 2 address.
- rd_data1  out  XLEN  read port 1 data.
- rd_data2  out  XLEN  read port 2 data.
- rd_busy1  out  1  register at rd_addr1 has a pending long-latency write.
- rd_busy2  out  1  register at rd_addr2 has a pending long-latency write.
- wr_en0  in  1  write enable, port 0 (ALU).
- wr_addr0  in  AW  write address, port 0.
- wr_data0  in  XLEN  write data, port 0.
- wr_en1  in  1  write enable, port 1 (long-latency writeback); also clears the pending bit.
- wr_addr1  in  AW  write address, port 1.
- wr_data1  in  XLEN  write data, port 1.
- sb_set  in  1  mark sb_addr pending; asserted when a long-latency op issues.
- sb_addr  in  AW  destination register of the issuing long-latency op.
- out_reg  out  XLEN  debug tap showing the committed value of register OUT_REG.

Behaviour:
- Reset (async, active-high): all registers become 0 and all pending bits become 0, immediately and without waiting for a clock edge.
  - While rst=1: rd_data1, rd_data2 and out_reg read 0; rd_busy1 and rd_busy2 read 0.
  - Writes and sb_set presented while rst=1 are discarded.
  - Reset asserted mid-operation drops all outstanding pending bits.
- Writes: registers update on the rising clk edge when the corresponding wr_en is high.
  - wr_en0 and wr_en1 both high with the same address: port 1 wins; port 0 data is discarded.
  - Different addresses: both writes commit in the same cycle.
- Reads: combinational from the addresses, zero-cycle latency.
  - With BYPASS=0, reads return the committed (pre-edge) value.
  - With BYPASS=1, a read address matching an active write address returns that write's data; port 1 takes priority over port 0.
- out_reg: always the committed value of OUT_REG, never bypassed.
- Zero register (ZERO_REG=1): reads of address 0 return 0 on both read ports, including through the bypass path.
  - Writes to address 0 are ignored.
  - sb_set with sb_addr=0 is ignored.
  - rd_busy is always 0 for address 0.
- Scoreboard: one pending bit per register.
  - Set on the rising edge when sb_set=1.
  - Cleared on the rising edge when wr_en1=1 at wr_addr1.
  - wr_en0 never touches pending bits.
  - sb_set and a wr_en1 clear on the same address in the same cycle: the set wins, so the bit ends at 1 (the new issue supersedes the old result).
  - Set and clear on different addresses apply independently.
  - sb_set on a register that is already pending leaves it pending; there is no counting.
- rd_busy: rd_busyN = pending[rd_addrN].
  - With BYPASS=1, rd_busyN is forced to 0 when wr_en1=1 and wr_addr1 equals rd_addrN in the same cycle, because the data is already available through the bypass.
- No further stalls or handshakes: the block never blocks a write, and throughput is two writes per cycle.

Test Plan:
- Reset: pulse rst asynchronously between clk edges after registers hold nonzero values -> rd_data1, rd_data2 and out_reg read 0 and rd_busy1, rd_busy2 read 0 with no clk edge; sb_set=1 at sb_addr=5 held during rst leaves rd_busy=0 for r5 after release.
- Dual write and conflict: wr0 writes r3=0xAAAA0000 while wr1 writes r7=0x12345678 -> both visible on the next cycle. Next, both ports write r4 (0x11 on port 0, 0x22 on port 1) -> r4 reads 0x22.
- Bypass (BYPASS=1): rd_addr1=9 while wr_en0 writes r9=0xDEADBEEF -> rd_data1=0xDEADBEEF in the same cycle. With port 1 also writing r9=0xCAFEF00D -> rd_data1=0xCAFEF00D. With BYPASS=0 -> rd_data1 shows the old value until after the edge.
- Zero register: write r0=0xFFFFFFFF on both ports and pulse sb_set at addr 0 -> rd_data1=rd_data2=0 and rd_busy=0 for r0, including the bypass cycle.
- Scoreboard: sb_set r10, then read r10 -> rd_busy1=1 for 3 cycles. On the cycle wr_en1 writes r10=0x55, rd_busy1=0 and rd_data1=0x55 (BYPASS=1), and the bit stays clear after. wr_en0 to r10 while pending -> still busy.
- Set/clear collision: r12 pending, then sb_set r12 and wr_en1 to r12 in the same cycle -> r12 = new data and rd_busy for r12 = 1 on the following cycle. out_reg tracks r6 writes one cycle after each write edge.
